mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single stalling unified memory between the fetch stage (instruction reads) and the memory stage (LD/ST/STU data accesses) of the pipelined WISC core.
- Sequences one outstanding access at a time and returns per-port done pulses, read data and stall signals.
- Fetch and memory stages freeze on these stalls.
- Flags illegal requests and memory timeouts on err, for the core's halt/exception path.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 31, max cycles from issue to mem_done before err; must be 1..255.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch read request; held with stable if_addr until if_done.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  instruction word; valid in if_done cycle, held until next fetch completion.
- if_done  out  1  one-cycle completion pulse, fetch port.
- if_stall  out  1  if_req & ~if_done.
- dm_rd  in  1  data read request (LD); held until dm_done.
- dm_wr  in  1  data write request (ST/STU); held until dm_done.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid in dm_done cycle, held until next data read completion.
- dm_done  out  1  one-cycle completion pulse, data port.
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done.
- mem_rd  out  1  memory read strobe, one cycle per access.
- mem_wr  out  1  memory write strobe, one cycle per access.
- mem_addr  out  AW  memory address, registered at issue.
- mem_wdata  out  DW  memory write data, registered at issue.
- mem_rdata  in  DW  memory read data, valid with mem_done.
- mem_stall  in  1  memory busy; no strobe may issue while high.
- mem_done  in  1  access complete.
- err  out  1  sticky error, cleared only by reset.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; rdata holding registers 0; timeout counter 0.
- States:
  - IDLE: arbitrate.
  - ISSUE: strobe cycle.
  - WAIT_IF: waiting on memory for fetch access.
  - WAIT_DM: waiting on memory for data access.
  - ERR: terminal.
- IDLE arbitration, evaluated each cycle with mem_stall=0:
  - Data port has fixed priority over fetch; it is the older instruction.
  - dm_rd&dm_wr both high -> err=1, go to ERR, no access issued.
- IDLE -> ISSUE:
  - Latch grant, address, wdata and direction.
  - In ISSUE, drive exactly one of mem_rd/mem_wr for one cycle.
  - Next state is WAIT_DM or WAIT_IF.
- WAIT_x:
  - Timeout counter increments each cycle.
  - On mem_done: capture mem_rdata into the granted port's holding register (reads only), pulse x_done that same cycle, return to IDLE.
  - Counter reaches TIMEOUT without mem_done -> err=1, go to ERR.
- Minimum access latency: grant cycle + issue cycle + memory latency. The next arbitration is the cycle after done.
- mem_done seen in IDLE/ISSUE (stale, e.g. after reset mid-access) is ignored.
- Requester drops its request mid-access: the access still completes, the done pulse is still emitted, and no retry is made.
- Requests arriving while busy wait; stall stays high.
- ERR: all strobes and done outputs are 0; stalls follow requests, so the core freezes.
- Fetch can starve during consecutive data accesses. This is accepted because data accesses stall the pipeline anyway.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds outputs if_wait_cnt[15:0] and dm_wait_cnt[15:0].
- Each counter increments every cycle its port's stall is high, saturates at 16'hFFFF, and resets to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE, ISSUE, WAIT_IF, WAIT_DM, ERR) and grant encoding (GNT_NONE, GNT_IF, GNT_DM).
- One sub-module, mem_arb_perf: the saturating counter pair, instantiated only under MEM_ARB_PERF_CNT_EN.

Test Plan:
- Reset mid-WAIT_DM, then mem_done arrives in IDLE -> no done pulse; outputs stay 0; next request issues normally.
- Lone if_req at addr 16'h0040, memory returns 16'hA5A5 after 4 cycles -> mem_rd one cycle with mem_addr=16'h0040; if_done pulses with if_rdata=16'hA5A5; if_stall high until then.
- if_req and dm_wr (addr 16'h1000, wdata 16'h1234) raised in the same cycle -> data write issued first (mem_wr, wdata 16'h1234); fetch issued after dm_done; no overlap of strobes.
- mem_stall held high 3 cycles while dm_rd is pending -> no strobe during those cycles; issue in the first cycle mem_stall is low.
- dm_rd and dm_wr raised together -> err=1, no strobe ever issued, dm_stall stays high; with TIMEOUT=4 and memory never responding, err=1 after 4 wait cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding, grant
// encoding, the timeout counter width and small helper functions.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_IF = 3'd2,
        WAIT_DM = 3'd3,
        ERR     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } gnt_e;

    // TIMEOUT is limited to 1..255, so an 8-bit counter always suffices.
    localparam int TMO_W = 8;

    // Wait state that follows the strobe cycle for a given grant.
    function automatic state_e wait_state(input gnt_e g);
        return (g == GNT_DM) ? WAIT_DM : WAIT_IF;
    endfunction

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Stall-cycle counters for the fetch and data ports. Each counter counts the
// cycles its port is stalled and saturates at 16'hFFFF. Only instantiated by
// mem_arbiter when MEM_ARB_PERF_CNT_EN is defined.
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        dm_stall,
    output logic [15:0] if_wait_cnt,
    output logic [15:0] dm_wait_cnt
);

    logic [15:0] if_cnt_q, if_cnt_d;
    logic [15:0] dm_cnt_q, dm_cnt_d;

    // Next count: bump while the port is stalled, never wrap.
    always_comb begin
        if_cnt_d = if_stall ? sat_inc16(if_cnt_q) : if_cnt_q;
        dm_cnt_d = dm_stall ? sat_inc16(dm_cnt_q) : dm_cnt_q;
    end

    // Counter registers, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_cnt_q <= 16'd0;
            dm_cnt_q <= 16'd0;
        end else begin
            if_cnt_q <= if_cnt_d;
            dm_cnt_q <= dm_cnt_d;
        end
    end

    assign if_wait_cnt = if_cnt_q;
    assign dm_wait_cnt = dm_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the fetch stage and the memory stage for one stalling
// unified memory. One access is in flight at a time; the data port wins
// over fetch. Illegal requests (read and write together) and memory
// timeouts raise a sticky err and park the FSM in ERR.
// Optional: define MEM_ARB_PERF_CNT_EN to add per-port stall counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          dm_rd,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          dm_stall,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_stall,
    input  logic          mem_done,
    output logic          err
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]   if_wait_cnt,
    output logic [15:0]   dm_wait_cnt
`endif
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_e             state_q, state_d;
    gnt_e               gnt_q, gnt_d;
    logic               dm_is_wr_q, dm_is_wr_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]      if_hold_q, if_hold_d;
    logic [DW-1:0]      dm_hold_q, dm_hold_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   tmo_inc;
    logic               err_q, err_d;

    assign tmo_inc = tmo_q + 1'b1;

    // Arbitration, strobe sequencing, completion capture and timeout.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        dm_is_wr_d  = dm_is_wr_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_hold_d   = if_hold_q;
        dm_hold_d   = dm_hold_q;
        tmo_d       = tmo_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (!mem_stall) begin
                    if (dm_rd && dm_wr) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else if (dm_rd || dm_wr) begin
                        gnt_d       = GNT_DM;
                        dm_is_wr_d  = dm_wr;
                        mem_rd_d    = dm_rd;
                        mem_wr_d    = dm_wr;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        state_d     = ISSUE;
                    end else if (if_req) begin
                        gnt_d      = GNT_IF;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = if_addr;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = wait_state(gnt_q);
            end
            WAIT_IF, WAIT_DM: begin
                if (mem_done) begin
                    if (state_q == WAIT_IF) begin
                        if_hold_d = mem_rdata;
                    end else if (!dm_is_wr_q) begin
                        dm_hold_d = mem_rdata;
                    end
                    gnt_d   = GNT_NONE;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; everything clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_NONE;
            dm_is_wr_q  <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_hold_q   <= '0;
            dm_hold_q   <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            dm_is_wr_q  <= dm_is_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_hold_q   <= if_hold_d;
            dm_hold_q   <= dm_hold_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end

    // Done pulses coincide with mem_done, so read data bypasses the holding
    // register in that cycle and is held from the register afterwards.
    assign if_done   = (state_q == WAIT_IF) && mem_done;
    assign dm_done   = (state_q == WAIT_DM) && mem_done;
    assign if_rdata  = if_done ? mem_rdata : if_hold_q;
    assign dm_rdata  = (dm_done && !dm_is_wr_q) ? mem_rdata : dm_hold_q;
    assign if_stall  = if_req & ~if_done;
    assign dm_stall  = (dm_rd | dm_wr) & ~dm_done;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

`ifdef MEM_ARB_PERF_CNT_EN
    mem_arb_perf u_perf (
        .clk         (clk),
        .rst         (rst),
        .if_stall    (if_stall),
        .dm_stall    (dm_stall),
        .if_wait_cnt (if_wait_cnt),
        .dm_wait_cnt (dm_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. A second instance with
// TIMEOUT=4 and a silent memory exercises the timeout path.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_rd, dm_wr, mem_stall, mem_done;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, if_stall, dm_done, dm_stall, mem_rd, mem_wr, err;

    logic        t_if_req, t_dm_rd, t_dm_wr, t_mem_done;
    logic [15:0] t_if_rdata, t_dm_rdata, t_mem_addr, t_mem_wdata;
    logic        t_if_done, t_if_stall, t_dm_done, t_dm_stall, t_mem_rd, t_mem_wr, t_err;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] if_wait_cnt, dm_wait_cnt, t_if_wait_cnt, t_dm_wait_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .mem_done(mem_done), .err(err)
`ifdef MEM_ARB_PERF_CNT_EN
        , .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt)
`endif
    );

    mem_arbiter #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst),
        .if_req(t_if_req), .if_addr(if_addr), .if_rdata(t_if_rdata),
        .if_done(t_if_done), .if_stall(t_if_stall),
        .dm_rd(t_dm_rd), .dm_wr(t_dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(t_dm_rdata), .dm_done(t_dm_done), .dm_stall(t_dm_stall),
        .mem_rd(t_mem_rd), .mem_wr(t_mem_wr), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .mem_done(t_mem_done), .err(t_err)
`ifdef MEM_ARB_PERF_CNT_EN
        , .if_wait_cnt(t_if_wait_cnt), .dm_wait_cnt(t_dm_wait_cnt)
`endif
    );

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 0; dm_rd = 0; dm_wr = 0; mem_stall = 0; mem_done = 0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0;
        t_if_req = 0; t_dm_rd = 0; t_dm_wr = 0; t_mem_done = 0;
        repeat (3) next_cyc();
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall, err} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall, err});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        checks++;
        if (t_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_t_err: got %b required 0", t_err);
        end
        next_cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        int  n;
        bit  seen;
        dm_rd = 1; dm_addr = 16'h2222;
        next_cyc();          // ISSUE
        next_cyc();          // WAIT_DM
        #2;
        rst = 1'b0; dm_rd = 0;
        #1;
        checks++;
        if ({mem_rd, dm_done, err, dm_stall} !== 4'b0) begin
            fails++;
            $display("FAIL reset_mid_async: got %b required 0000", {mem_rd, dm_done, err, dm_stall});
        end
        next_cyc();
        rst = 1'b1;
        mem_done = 1; mem_rdata = 16'hBEEF;   // stale completion in IDLE
        @(negedge clk);
        checks++;
        if ({dm_done, if_done} !== 2'b00 || dm_rdata !== 16'h0) begin
            fails++;
            $display("FAIL stale_done: got done=%b rdata=%h required 00 0000", {dm_done, if_done}, dm_rdata);
        end
        next_cyc();
        mem_done = 0;
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_wr, err} !== 3'b0 || dm_rdata !== 16'h0) begin
            fails++;
            $display("FAIL stale_after: got %b rdata=%h required 000 0000", {mem_rd, mem_wr, err}, dm_rdata);
        end
        next_cyc();
        dm_rd = 1; dm_addr = 16'h3333;
        seen = 0; n = -1;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) begin
                seen = 1; n = i;
            end else begin
                next_cyc();
            end
        end
        checks++;
        if (!seen || n != 1 || mem_rd !== 1'b1 || mem_addr !== 16'h3333) begin
            fails++;
            $display("FAIL post_reset_issue: got seen=%0d cyc=%0d rd=%b addr=%h required 1 1 1 3333",
                     seen, n, mem_rd, mem_addr);
        end
        next_cyc();
        mem_done = 1; mem_rdata = 16'h5A5A;
        @(negedge clk);
        checks++;
        if (dm_done !== 1'b1 || dm_rdata !== 16'h5A5A || dm_stall !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_done: got done=%b rdata=%h stall=%b required 1 5a5a 0",
                     dm_done, dm_rdata, dm_stall);
        end
        next_cyc();
        mem_done = 0; dm_rd = 0;
    endtask

    task automatic test_fetch();
        bit stall_ok = 1;
        if_req = 1; if_addr = 16'h0040;
        @(negedge clk);
        checks++;
        if (if_stall !== 1'b1 || mem_rd !== 1'b0) begin
            fails++;
            $display("FAIL fetch_grant: got stall=%b rd=%b required 1 0", if_stall, mem_rd);
        end
        next_cyc();
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0040) begin
            fails++;
            $display("FAIL fetch_strobe: got rd=%b wr=%b addr=%h required 1 0 0040", mem_rd, mem_wr, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            @(negedge clk);
            if (if_stall !== 1'b1 || if_done !== 1'b0 || mem_rd !== 1'b0) stall_ok = 0;
        end
        checks++;
        if (!stall_ok) begin
            fails++;
            $display("FAIL fetch_wait: got stall/done/strobe wrong in wait cycles required stall=1 done=0 rd=0");
        end
        next_cyc();
        mem_done = 1; mem_rdata = 16'hA5A5;
        @(negedge clk);
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 16'hA5A5 || if_stall !== 1'b0) begin
            fails++;
            $display("FAIL fetch_done: got done=%b rdata=%h stall=%b required 1 a5a5 0", if_done, if_rdata, if_stall);
        end
        next_cyc();
        mem_done = 0; if_req = 0; mem_rdata = 16'h0000;
        @(negedge clk);
        checks++;
        if (if_done !== 1'b0 || if_rdata !== 16'hA5A5) begin
            fails++;
            $display("FAIL fetch_hold: got done=%b rdata=%h required 0 a5a5", if_done, if_rdata);
        end
        next_cyc();
    endtask

    task automatic test_priority();
        int          done_at = -100;
        int          nstrobe = 0;
        int          s_cyc[2];
        logic [15:0] s_addr[2];
        logic        s_wr[2];
        logic [15:0] s_wdata = 16'h0;
        bit          overlap = 0, dm_seen = 0, if_seen = 0;
        int          dm_done_c = -1;
        logic [15:0] if_got = 16'h0;
        s_cyc[0] = -1; s_cyc[1] = -1;
        s_addr[0] = 16'h0; s_addr[1] = 16'h0; s_wr[0] = 0; s_wr[1] = 0;
        if_req = 1; if_addr = 16'h0080;
        dm_wr = 1; dm_addr = 16'h1000; dm_wdata = 16'h1234;
        for (int c = 0; c < 20; c++) begin
            mem_done  = (c == done_at);
            mem_rdata = 16'h0F0F;
            @(negedge clk);
            if (mem_rd && mem_wr) overlap = 1;
            if (mem_rd || mem_wr) begin
                if (nstrobe < 2) begin
                    s_cyc[nstrobe] = c; s_addr[nstrobe] = mem_addr; s_wr[nstrobe] = mem_wr;
                    if (nstrobe == 0) s_wdata = mem_wdata;
                end
                nstrobe++;
                done_at = c + 2;
            end
            if (dm_done && !dm_seen) begin dm_seen = 1; dm_done_c = c; end
            if (if_done && !if_seen) begin if_seen = 1; if_got = if_rdata; end
            next_cyc();
            if (dm_seen) dm_wr = 0;
            if (if_seen) if_req = 0;
        end
        mem_done = 0;
        checks++;
        if (nstrobe != 2 || overlap) begin
            fails++;
            $display("FAIL prio_count: got strobes=%0d overlap=%0d required 2 0", nstrobe, overlap);
        end
        checks++;
        if (s_cyc[0] != 1 || s_wr[0] !== 1'b1 || s_addr[0] !== 16'h1000 || s_wdata !== 16'h1234) begin
            fails++;
            $display("FAIL prio_first_dm: got cyc=%0d wr=%b addr=%h wdata=%h required 1 1 1000 1234",
                     s_cyc[0], s_wr[0], s_addr[0], s_wdata);
        end
        checks++;
        if (!dm_seen || s_cyc[1] != dm_done_c + 2 || s_wr[1] !== 1'b0 || s_addr[1] !== 16'h0080) begin
            fails++;
            $display("FAIL prio_then_if: got cyc=%0d dmdone=%0d wr=%b addr=%h required dmdone+2 0 0080",
                     s_cyc[1], dm_done_c, s_wr[1], s_addr[1]);
        end
        checks++;
        if (!if_seen || if_got !== 16'h0F0F || dm_rdata !== 16'h5A5A) begin
            fails++;
            $display("FAIL prio_rdata: got if_seen=%0d if_rdata=%h dm_rdata=%h required 1 0f0f 5a5a",
                     if_seen, if_got, dm_rdata);
        end
    endtask

    task automatic test_mem_stall();
        bit quiet = 1, stall_hi = 1;
        mem_stall = 1; dm_rd = 1; dm_addr = 16'h2468;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) quiet = 0;
            if (dm_stall !== 1'b1) stall_hi = 0;
            next_cyc();
        end
        mem_stall = 0;
        @(negedge clk);
        if (mem_rd || mem_wr) quiet = 0;
        checks++;
        if (!quiet || !stall_hi) begin
            fails++;
            $display("FAIL mstall_quiet: got quiet=%0d stall_hi=%0d required 1 1", quiet, stall_hi);
        end
        next_cyc();
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h2468) begin
            fails++;
            $display("FAIL mstall_issue: got rd=%b addr=%h required 1 2468", mem_rd, mem_addr);
        end
        next_cyc();
        mem_done = 1; mem_rdata = 16'h7777;
        @(negedge clk);
        checks++;
        if (dm_done !== 1'b1 || dm_rdata !== 16'h7777) begin
            fails++;
            $display("FAIL mstall_done: got done=%b rdata=%h required 1 7777", dm_done, dm_rdata);
        end
        next_cyc();
        mem_done = 0; dm_rd = 0;
        next_cyc();
    endtask

    task automatic test_drop_request();
        bit retry = 0;
        if_req = 1; if_addr = 16'h0100;
        next_cyc();               // ISSUE
        if_req = 0;
        next_cyc();               // first wait cycle
        mem_done = 1; mem_rdata = 16'hCAFE;
        @(negedge clk);
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 16'hCAFE || if_stall !== 1'b0) begin
            fails++;
            $display("FAIL drop_done: got done=%b rdata=%h stall=%b required 1 cafe 0", if_done, if_rdata, if_stall);
        end
        next_cyc();
        mem_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) retry = 1;
            next_cyc();
        end
        checks++;
        if (retry) begin
            fails++;
            $display("FAIL drop_no_retry: got strobe after dropped request required none");
        end
    endtask

    task automatic test_timeout();
        int strobes = 0, strobe_c = -1, err_c = -1;
        bit stall_hi = 1, any_done = 0;
        t_dm_rd = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (t_mem_rd || t_mem_wr) begin strobes++; strobe_c = c; end
            if (t_err === 1'b1 && err_c < 0) err_c = c;
            if (t_dm_stall !== 1'b1) stall_hi = 0;
            if (t_dm_done || t_if_done) any_done = 1;
            next_cyc();
        end
        checks++;
        if (strobes != 1 || strobe_c != 1) begin
            fails++;
            $display("FAIL tmo_strobe: got strobes=%0d at=%0d required 1 1", strobes, strobe_c);
        end
        checks++;
        if (err_c != 6) begin
            fails++;
            $display("FAIL tmo_err_cycle: got %0d required 6", err_c);
        end
        checks++;
        if (!stall_hi || any_done) begin
            fails++;
            $display("FAIL tmo_stall: got stall_hi=%0d any_done=%0d required 1 0", stall_hi, any_done);
        end
        t_dm_rd = 0;
    endtask

    task automatic test_illegal();
        bit strobe = 0, stall_hi = 1, any_done = 0;
        int err_c = -1;
        dm_rd = 1; dm_wr = 1; dm_addr = 16'h4444;
        for (int c = 0; c < 6; c++) begin
            mem_done = (c == 3);
            @(negedge clk);
            if (mem_rd || mem_wr) strobe = 1;
            if (dm_stall !== 1'b1) stall_hi = 0;
            if (dm_done || if_done) any_done = 1;
            if (err === 1'b1 && err_c < 0) err_c = c;
            next_cyc();
        end
        mem_done = 0;
        checks++;
        if (err_c != 1) begin
            fails++;
            $display("FAIL illegal_err: got first err cycle %0d required 1", err_c);
        end
        checks++;
        if (strobe || !stall_hi || any_done) begin
            fails++;
            $display("FAIL illegal_frozen: got strobe=%0d stall_hi=%0d done=%0d required 0 1 0",
                     strobe, stall_hi, any_done);
        end
        dm_rd = 0; dm_wr = 0; if_req = 1; if_addr = 16'h0200;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd || mem_wr) strobe = 1;
            next_cyc();
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || strobe || if_stall !== 1'b1 || dm_stall !== 1'b0) begin
            fails++;
            $display("FAIL err_sticky: got err=%b strobe=%0d if_stall=%b dm_stall=%b required 1 0 1 0",
                     err, strobe, if_stall, dm_stall);
        end
        if_req = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_reset_mid_access();
        test_fetch();
        test_priority();
        test_mem_stall();
        test_drop_request();
        test_timeout();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
